// File: rtl/pipelined_control_unit.sv
// LEGv8 main decoder for a 5-stage pipeline: decodes the ID opcode and carries
// the control bits through the ID/EX, EX/MEM and MEM/WB control registers.
package pipelined_control_unit_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
    } ex_ctrl_t;

    typedef struct packed {
        logic read;
        logic write;
        logic branch;
        logic uncond;
        logic bnz;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } id_ex_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ex_mem_t;

endpackage

module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter int unsigned OPCODE_W   = 11,
    parameter bit          ENABLE_IMM = 1'b1,
    parameter int unsigned ILL_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 id_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 reg2loc,
    output logic                 ex_alusrc,
    output logic [1:0]           ex_aluop,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_branch,
    output logic                 mem_uncond,
    output logic                 mem_bnz,
    output logic                 wb_regwrite,
    output logic                 wb_memtoreg,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam int unsigned DEC_W = 11;

    logic [DEC_W-1:0]     op_c;
    id_ex_t               dec_c;
    logic                 reg2loc_c;
    logic                 ill_c;
    logic                 ill_event_c;

    id_ex_t               id_ex_d,  id_ex_q;
    ex_mem_t              ex_mem_d, ex_mem_q;
    wb_ctrl_t             mem_wb_d, mem_wb_q;
    logic                 illegal_d, illegal_q;
    logic [ILL_CNT_W-1:0] ill_count_d, ill_count_q;

    assign op_c = opcode[OPCODE_W-1 -: DEC_W];

    // Opcode decode; an empty IF/ID slot decodes as a bubble.
    always_comb begin
        dec_c     = '0;
        reg2loc_c = 1'b0;
        ill_c     = 1'b0;
        casez (op_c)
            11'b11111000010: begin
                reg2loc_c       = 1'b1;
                dec_c.ex.alusrc = 1'b1;
                dec_c.ex.aluop  = ALUOP_ADD;
                dec_c.mem.read  = 1'b1;
                dec_c.wb        = '{regwrite: 1'b1, memtoreg: 1'b1};
            end
            11'b11111000000: begin
                reg2loc_c       = 1'b1;
                dec_c.ex.alusrc = 1'b1;
                dec_c.ex.aluop  = ALUOP_ADD;
                dec_c.mem.write = 1'b1;
            end
            11'b1??0101?000: begin
                dec_c.ex.aluop     = ALUOP_RTYPE;
                dec_c.wb.regwrite  = 1'b1;
            end
            11'b10110100???,
            11'b10110101???: begin
                reg2loc_c        = 1'b1;
                dec_c.ex.aluop   = ALUOP_PASSB;
                dec_c.mem.branch = 1'b1;
                dec_c.mem.bnz    = op_c[3];
            end
            11'b000101?????: begin
                dec_c.mem.uncond = 1'b1;
            end
            11'b1001000100?,
            11'b1101000100?: begin
                if (ENABLE_IMM) begin
                    dec_c.ex.alusrc   = 1'b1;
                    dec_c.ex.aluop    = ALUOP_IMM;
                    dec_c.wb.regwrite = 1'b1;
                end else begin
                    ill_c = 1'b1;
                end
            end
            default: ill_c = 1'b1;
        endcase
        if (!id_valid) begin
            dec_c     = '0;
            reg2loc_c = 1'b0;
            ill_c     = 1'b0;
        end
    end

    // Flush kills both younger stages; a stall only bubbles ID/EX.
    always_comb begin
        ill_event_c = ill_c & ~stall & ~flush;
        id_ex_d     = (flush || stall) ? id_ex_t'('0) : dec_c;
        ex_mem_d    = flush ? ex_mem_t'('0) : '{mem: id_ex_q.mem, wb: id_ex_q.wb};
        mem_wb_d    = ex_mem_q.wb;
        illegal_d   = illegal_q | ill_event_c;
        ill_count_d = ill_count_q;
        if (ill_event_c && (ill_count_q != {ILL_CNT_W{1'b1}})) begin
            ill_count_d = ill_count_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q     <= '0;
            ex_mem_q    <= '0;
            mem_wb_q    <= '0;
            illegal_q   <= 1'b0;
            ill_count_q <= '0;
        end else begin
            id_ex_q     <= id_ex_d;
            ex_mem_q    <= ex_mem_d;
            mem_wb_q    <= mem_wb_d;
            illegal_q   <= illegal_d;
            ill_count_q <= ill_count_d;
        end
    end

    assign reg2loc     = reg2loc_c;
    assign ex_alusrc   = id_ex_q.ex.alusrc;
    assign ex_aluop    = id_ex_q.ex.aluop;
    assign mem_read    = ex_mem_q.mem.read;
    assign mem_write   = ex_mem_q.mem.write;
    assign mem_branch  = ex_mem_q.mem.branch;
    assign mem_uncond  = ex_mem_q.mem.uncond;
    assign mem_bnz     = ex_mem_q.mem.bnz;
    assign wb_regwrite = mem_wb_q.regwrite;
    assign wb_memtoreg = mem_wb_q.memtoreg;
    assign illegal     = illegal_q;
    assign ill_count   = ill_count_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench: two decoder instances (ADDI/SUBI enabled and disabled)
// checked every cycle against a stage-shift reference model, plus directed pins.
module tb_pipelined_control_unit;

    localparam int unsigned OW   = 11;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101010;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;

    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       rd, wr, br, unc, bnz, rw, m2r, r2l, ill;
    } ctl_t;

    logic          clk = 1'b0;
    logic          reset, id_valid, stall, flush;
    logic [OW-1:0] opcode;

    logic [1:0]    reg2loc, ex_alusrc, mem_read, mem_write, mem_branch, mem_uncond;
    logic [1:0]    mem_bnz, wb_regwrite, wb_memtoreg, illegal;
    logic [1:0]    ex_aluop  [2];
    logic [CW-1:0] ill_count [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_control_unit #(.OPCODE_W(OW), .ENABLE_IMM(1'b1), .ILL_CNT_W(CW)) u_imm (
        .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid), .stall(stall),
        .flush(flush), .reg2loc(reg2loc[0]), .ex_alusrc(ex_alusrc[0]), .ex_aluop(ex_aluop[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_branch(mem_branch[0]),
        .mem_uncond(mem_uncond[0]), .mem_bnz(mem_bnz[0]), .wb_regwrite(wb_regwrite[0]),
        .wb_memtoreg(wb_memtoreg[0]), .illegal(illegal[0]), .ill_count(ill_count[0])
    );

    pipelined_control_unit #(.OPCODE_W(OW), .ENABLE_IMM(1'b0), .ILL_CNT_W(CW)) u_noimm (
        .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid), .stall(stall),
        .flush(flush), .reg2loc(reg2loc[1]), .ex_alusrc(ex_alusrc[1]), .ex_aluop(ex_aluop[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_branch(mem_branch[1]),
        .mem_uncond(mem_uncond[1]), .mem_bnz(mem_bnz[1]), .wb_regwrite(wb_regwrite[1]),
        .wb_memtoreg(wb_memtoreg[1]), .illegal(illegal[1]), .ill_count(ill_count[1])
    );

    // Instruction classes written straight from the opcode table.
    function automatic ctl_t decode(input logic [10:0] op, input bit en_imm);
        ctl_t d = '0;
        if (op == OP_LDUR) begin
            d.r2l = 1; d.alusrc = 1; d.m2r = 1; d.rw = 1; d.rd = 1;
        end else if (op == OP_STUR) begin
            d.r2l = 1; d.alusrc = 1; d.wr = 1;
        end else if (op ==? 11'b1??0101?000) begin
            d.rw = 1; d.aluop = 2'b10;
        end else if (op ==? 11'b1011010????) begin
            d.r2l = 1; d.br = 1; d.aluop = 2'b01; d.bnz = op[3];
        end else if (op ==? 11'b000101?????) begin
            d.unc = 1;
        end else if (en_imm && ((op ==? 11'b1001000100?) || (op ==? 11'b1101000100?))) begin
            d.alusrc = 1; d.rw = 1; d.aluop = 2'b11;
        end else begin
            d.ill = 1;
        end
        return d;
    endfunction

    ctl_t m_ex [2];
    ctl_t m_mem [2];
    ctl_t m_wb [2];
    bit   m_ill [2];
    int   m_cnt [2];
    bit   model_live = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ctl_t d;
            bit   counted;
            d       = id_valid ? decode(opcode, i == 0) : ctl_t'('0);
            counted = id_valid && !stall && !flush && d.ill;
            if (reset) begin
                m_ex[i]  <= '0;
                m_mem[i] <= '0;
                m_wb[i]  <= '0;
                m_ill[i] <= 1'b0;
                m_cnt[i] <= 0;
            end else begin
                m_wb[i]  <= m_mem[i];
                m_mem[i] <= flush ? ctl_t'('0) : m_ex[i];
                m_ex[i]  <= (flush || stall) ? ctl_t'('0) : d;
                m_ill[i] <= m_ill[i] | counted;
                m_cnt[i] <= (counted && m_cnt[i] < CMAX) ? m_cnt[i] + 1 : m_cnt[i];
            end
        end
        if (reset) model_live <= 1'b1;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, inst, $time, got, exp);
        end
    endtask

    // Whole-output comparison against the model every cycle.
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                logic [19:0] got, exp;
                ctl_t d;
                d   = id_valid ? decode(opcode, i == 0) : ctl_t'('0);
                got = {reg2loc[i], ex_alusrc[i], ex_aluop[i], mem_read[i], mem_write[i],
                       mem_branch[i], mem_uncond[i], mem_bnz[i], wb_regwrite[i],
                       wb_memtoreg[i], illegal[i], ill_count[i]};
                exp = {d.r2l, m_ex[i].alusrc, m_ex[i].aluop, m_mem[i].rd, m_mem[i].wr,
                       m_mem[i].br, m_mem[i].unc, m_mem[i].bnz, m_wb[i].rw, m_wb[i].m2r,
                       m_ill[i], CW'(m_cnt[i])};
                chk("model_vec", i, 32'(got), 32'(exp));
            end
        end
    end

    task automatic step(input logic [10:0] op, input logic v, input logic st,
                        input logic fl, input logic rs);
        reset = rs; opcode = op; id_valid = v; stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] rand_op();
        case ($urandom_range(0, 11))
            0:       return 11'b10001011000;
            1:       return 11'b11001011000;
            2:       return 11'b10001010000;
            3:       return 11'b10101010000;
            4:       return OP_LDUR;
            5:       return OP_STUR;
            6:       return {8'b10110100, 3'($urandom)};
            7:       return {8'b10110101, 3'($urandom)};
            8:       return {6'b000101, 5'($urandom)};
            9:       return {10'b1001000100, 1'($urandom)};
            10:      return {10'b1101000100, 1'($urandom)};
            default: return 11'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; opcode = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        step(11'h0, 0, 0, 0, 1);
        chk("rst_ex_alusrc", 0, 32'(ex_alusrc[0]), 0);
        chk("rst_wb_regwrite", 0, 32'(wb_regwrite[0]), 0);
        chk("rst_ill_count", 1, 32'(ill_count[1]), 0);

        // LDUR through all three stages
        step(OP_LDUR, 1, 0, 0, 0);
        chk("ldur_ex_alusrc", 0, 32'(ex_alusrc[0]), 1);
        chk("ldur_ex_aluop", 0, 32'(ex_aluop[0]), 0);
        step(11'h0, 0, 0, 0, 0);
        chk("ldur_mem_read", 0, 32'(mem_read[0]), 1);
        chk("ldur_mem_uncond", 0, 32'(mem_uncond[0]), 0);
        step(11'h0, 0, 0, 0, 0);
        chk("ldur_wb_regwrite", 0, 32'(wb_regwrite[0]), 1);
        chk("ldur_wb_memtoreg", 0, 32'(wb_memtoreg[0]), 1);

        // ADD then CBNZ back to back
        step(OP_ADD, 1, 0, 0, 0);
        chk("add_ex_aluop", 0, 32'(ex_aluop[0]), 2);
        step(OP_CBNZ, 1, 0, 0, 0);
        chk("cbnz_ex_aluop", 0, 32'(ex_aluop[0]), 1);
        step(11'h0, 0, 0, 0, 0);
        chk("cbnz_mem_branch", 0, 32'(mem_branch[0]), 1);
        chk("cbnz_mem_bnz", 0, 32'(mem_bnz[0]), 1);
        chk("cbnz_mem_write", 0, 32'(mem_write[0]), 0);

        // STUR followed by a stalled LDUR
        step(OP_STUR, 1, 0, 0, 0);
        step(OP_LDUR, 1, 1, 0, 0);
        chk("stall_ex_alusrc", 0, 32'(ex_alusrc[0]), 0);
        chk("stall_ex_aluop", 0, 32'(ex_aluop[0]), 0);
        chk("stall_stur_mem_write", 0, 32'(mem_write[0]), 1);

        // B in MEM, flush kills younger STUR and LDUR
        step(OP_B, 1, 0, 0, 0);
        step(OP_STUR, 1, 0, 0, 0);
        chk("b_mem_uncond", 0, 32'(mem_uncond[0]), 1);
        step(OP_LDUR, 1, 0, 1, 0);
        chk("flush_ex_alusrc", 0, 32'(ex_alusrc[0]), 0);
        chk("flush_mem_write", 0, 32'(mem_write[0]), 0);
        chk("flush_b_wb_regwrite", 0, 32'(wb_regwrite[0]), 0);

        // flush and stall together behave like flush
        step(OP_LDUR, 1, 0, 0, 0);
        step(OP_ADD, 1, 1, 1, 0);
        chk("fs_ex_aluop", 0, 32'(ex_aluop[0]), 0);
        chk("fs_mem_read", 0, 32'(mem_read[0]), 0);

        // ADDI legal only with immediates enabled
        step(OP_ADDI, 1, 0, 0, 0);
        chk("addi_imm_aluop", 0, 32'(ex_aluop[0]), 3);
        chk("addi_imm_illegal", 0, 32'(illegal[0]), 0);
        chk("addi_noimm_aluop", 1, 32'(ex_aluop[1]), 0);
        chk("addi_noimm_illegal", 1, 32'(illegal[1]), 1);
        chk("addi_noimm_count", 1, 32'(ill_count[1]), 1);
        for (int k = 0; k < 300; k++) step(11'h000, 1, 0, 0, 0);
        chk("sat_count", 1, 32'(ill_count[1]), 255);
        chk("sat_count", 0, 32'(ill_count[0]), 255);

        // reset with STUR in EX/MEM
        step(OP_STUR, 1, 0, 0, 0);
        step(11'h0, 0, 0, 0, 0);
        chk("pre_rst_mem_write", 0, 32'(mem_write[0]), 1);
        step(OP_LDUR, 1, 1, 1, 1);
        chk("rst_mem_write", 0, 32'(mem_write[0]), 0);
        chk("rst_illegal", 1, 32'(illegal[1]), 0);
        chk("rst_ill_count2", 1, 32'(ill_count[1]), 0);

        // randomized traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            step(rand_op(), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);
        end

        step(11'h0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Main decoder for the 5-stage LEGv8 pipeline: decodes the 11-bit opcode in ID and carries control bits through the ID/EX, EX/MEM and MEM/WB control registers. It adds stall bubbles, branch flush, CBNZ/B/ADDI/SUBI decode and illegal-opcode detection. Sits beside the IF/ID register and feeds the hazard unit, the ALU control and the datapath muxes of each stage.

Parameters:
OPCODE_W, 11, opcode field width; only the upper 11 bits are decoded, extra LSBs are ignored.
ENABLE_IMM, 1, 1 = decode ADDI/SUBI; 0 = treat them as illegal.
ILL_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
opcode  in  OPCODE_W  instruction[31:21] from IF/ID.
id_valid  in  1  IF/ID holds a real instruction.
stall  in  1  hazard unit load-use stall.
flush  in  1  taken branch resolved in MEM.
reg2loc  out  1  ID-stage, combinational.
ex_alusrc  out  1  EX-stage ALUSrc.
ex_aluop  out  2  EX-stage ALUOp: 00 add, 01 pass-B (compare), 10 R-type funct, 11 immediate.
mem_read, mem_write, mem_branch, mem_uncond, mem_bnz  out  1 each  MEM-stage controls; mem_bnz=1 inverts Zero for CBNZ.
wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls.
illegal  out  1  sticky flag: an illegal opcode was decoded.
ill_count  out  ILL_CNT_W  saturating illegal-opcode count.

Behaviour:
- Decode, with x = don't care; every field not listed is 0:
  - R-type 1xx0101x000: regwrite=1, aluop=10.
  - LDUR 11111000010: reg2loc=1, alusrc=1, memtoreg=1, regwrite=1, memread=1, aluop=00.
  - STUR 11111000000: reg2loc=1, alusrc=1, memwrite=1, aluop=00.
  - CBZ 10110100xxx: reg2loc=1, branch=1, aluop=01.
  - CBNZ 10110101xxx: same as CBZ plus bnz=1.
  - B 000101xxxxx: uncond=1.
  - ADDI 1001000100x and SUBI 1101000100x (only if ENABLE_IMM): alusrc=1, regwrite=1, aluop=11.
  - Any other opcode: all controls 0 and the opcode is counted as illegal.
- uncond is 1 only for B. This corrects the previous decoder, which drove UnCondBranch=1 for every class.
- id_valid=0: the decode is forced to all-zero (a bubble); it is not counted as illegal and reg2loc=0.
- Pipeline registers advance on each clk:
  - ID/EX <= decode
  - EX/MEM <= ID/EX
  - MEM/WB <= EX/MEM
  - Each output reflects its own stage register.
- stall=1: ID/EX loads all-zero (bubble); EX/MEM and MEM/WB advance normally; no illegal count that cycle.
- flush=1: ID/EX and EX/MEM load all-zero; MEM/WB advances from the old EX/MEM. The instruction now in MEM completes its writeback.
- flush and stall both 1: flush wins; the same result as flush alone.
- Latency: the decode of an instruction accepted at edge N is visible on ex_* after edge N, on mem_* after N+1, and on wb_* after N+2.
- illegal sets when id_valid=1, stall=0, flush=0 and the opcode is illegal. It clears only on reset.
- ill_count increments under the same condition and saturates at all-ones.
- reset=1 at an edge: every stage register, illegal and ill_count go to 0. reset overrides stall and flush, including mid-instruction.
- After reset, all registered outputs read 0 until the first valid decode.

Test Plan:
- Reset then LDUR 11111000010 with id_valid=1 -> cycle+1: ex_alusrc=1, ex_aluop=00; +2: mem_read=1, mem_uncond=0; +3: wb_regwrite=1, wb_memtoreg=1.
- ADD 10001011000 then CBNZ 10110101010, back-to-back -> ex_aluop 10 then 01; next cycle mem_branch=1, mem_bnz=1, mem_write=0.
- LDUR with stall=1 for one cycle -> ex_* all 0 that cycle; previously issued STUR still reaches mem_write=1 on schedule.
- Issue B 00010100000, then assert flush while B is in MEM -> younger ID/EX and EX/MEM contents are zeroed; B's wb_* all 0; no stray mem_write.
- ENABLE_IMM=0, ADDI 10010001000 -> all controls 0, illegal=1, ill_count=1. Then 300 illegal opcodes at ILL_CNT_W=8 -> ill_count=255.
- Reset asserted while STUR is in EX/MEM -> next cycle mem_write=0, illegal=0, ill_count=0.
